// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Instruction fetch stage. It holds the PC register, a synchronous-read
// instruction memory and a small prefetch queue that decouples fetch from
// decode. Decode pulls entries with a valid/ready handshake. A taken
// branch/jump redirects the PC and flushes everything in flight. The
// debug/program loader can write the instruction memory.
//
// Ports
//   clk                     clock; all state changes on the rising edge
//   rst                     synchronous reset, active-high
//   i_step                  fetch enable (0: no new issue, queue still drains)
//   i_program_memory_write  write i_instruction_write at i_address_write
//   i_instruction_write     program word to store
//   i_address_write         word address of the program write
//   i_taken                 redirect request; flushes queue and in-flight read
//   i_branch_address        redirect target PC
//   i_ready                 decode accepts the head entry this cycle
//   o_valid                 head entry valid
//   o_instruction           head instruction
//   o_pc                    byte address of the head instruction
//   o_pc_next               o_pc + 4
//   o_count                 queue occupancy
//   o_fetch_pc              current PC register (debug view)
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
  parameter int                ADDR_W      = 32,
  parameter int                INST_W      = 32,
  parameter int                MEM_AW      = 8,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_step,
  input  logic                           i_program_memory_write,
  input  logic [INST_W-1:0]              i_instruction_write,
  input  logic [MEM_AW-1:0]              i_address_write,
  input  logic                           i_taken,
  input  logic [ADDR_W-1:0]              i_branch_address,
  input  logic                           i_ready,
  output logic                           o_valid,
  output logic [INST_W-1:0]              o_instruction,
  output logic [ADDR_W-1:0]              o_pc,
  output logic [ADDR_W-1:0]              o_pc_next,
  output logic [$clog2(QUEUE_DEPTH):0]   o_count,
  output logic [ADDR_W-1:0]              o_fetch_pc
);

  localparam int PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  // Instruction memory (contents survive reset).
  logic [INST_W-1:0] r_mem [MEM_DEPTH];

  // Fetch PC.
  logic [ADDR_W-1:0] r_pc;

  // Memory read in flight; its valid is the in-flight flag.
  logic              r_vld_p1;
  logic [INST_W-1:0] r_inst_p1;
  logic [ADDR_W-1:0] r_pc_p1;

  // Prefetch queue storage and control.
  logic [INST_W-1:0] r_q_inst [QUEUE_DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Registered copy of the queue head driven onto the outputs.
  logic [INST_W-1:0] r_out_inst;
  logic [ADDR_W-1:0] r_out_pc;
  logic [ADDR_W-1:0] r_out_pc_next;

  logic [CNT_W-1:0]  w_occ;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [MEM_AW-1:0] w_rd_idx;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_remain;
  logic              w_head_load;
  logic [INST_W-1:0] w_head_inst;
  logic [ADDR_W-1:0] w_head_pc;

  always_comb begin
    // The in-flight read counts against capacity so its push can never overflow.
    w_occ        = r_count + CNT_W'(r_vld_p1);
    w_issue      = i_step & ~i_program_memory_write & ~i_taken &
                   (w_occ < CNT_W'(QUEUE_DEPTH));
    w_push       = r_vld_p1 & ~i_taken;
    w_pop        = (r_count != '0) & i_ready & ~i_taken;
    // PC bits above the memory range alias; the byte offset is ignored.
    w_rd_idx     = r_pc[MEM_AW+1:2];
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    w_remain     = r_count - CNT_W'(w_pop);

    // Next head: the oldest remaining entry, or the word being pushed into
    // an otherwise empty queue. Otherwise the outputs keep their last value.
    w_head_load  = 1'b0;
    w_head_inst  = r_out_inst;
    w_head_pc    = r_out_pc;
    if (!i_taken && (w_remain != '0)) begin
      w_head_load = 1'b1;
      w_head_inst = r_q_inst[w_rd_ptr_nxt];
      w_head_pc   = r_q_pc[w_rd_ptr_nxt];
    end else if (w_push) begin
      w_head_load = 1'b1;
      w_head_inst = r_inst_p1;
      w_head_pc   = r_pc_p1;
    end
  end

  // ---- stage 0 -> 1: instruction memory write port and synchronous read ----
  always_ff @(posedge clk) begin
    if (i_program_memory_write) begin
      r_mem[i_address_write] <= i_instruction_write;
    end
    if (w_issue) begin
      r_inst_p1 <= r_mem[w_rd_idx];
      r_pc_p1   <= r_pc;
    end
  end

  // ---- stage 1 -> 2: push the returned word into the queue ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= r_inst_p1;
      r_q_pc[r_wr_ptr]   <= r_pc_p1;
    end
  end

  // Control: PC, in-flight flag, queue pointers/count, head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_vld_p1      <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_out_inst    <= '0;
      r_out_pc      <= '0;
      r_out_pc_next <= '0;
    end else if (i_taken) begin
      // Redirect: drop queued entries and kill the in-flight read.
      r_pc     <= i_branch_address;
      r_vld_p1 <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + ADDR_W'(4);
      end
      r_vld_p1 <= w_issue;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_remain + CNT_W'(w_push);
      if (w_head_load) begin
        r_out_inst    <= w_head_inst;
        r_out_pc      <= w_head_pc;
        r_out_pc_next <= w_head_pc + ADDR_W'(4);
      end
    end
  end

  assign o_valid       = (r_count != '0);
  assign o_instruction = r_out_inst;
  assign o_pc          = r_out_pc;
  assign o_pc_next     = r_out_pc_next;
  assign o_count       = r_count;
  assign o_fetch_pc    = r_pc;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_step = 1'b0;
  logic        i_program_memory_write = 1'b0;
  logic [31:0] i_instruction_write = '0;
  logic [7:0]  i_address_write = '0;
  logic        i_taken = 1'b0;
  logic [31:0] i_branch_address = '0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic [31:0] o_pc_next;
  logic [2:0]  o_count;
  logic [31:0] o_fetch_pc;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(
    .ADDR_W(32), .INST_W(32), .MEM_AW(8), .QUEUE_DEPTH(QD), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .i_step(i_step),
    .i_program_memory_write(i_program_memory_write),
    .i_instruction_write(i_instruction_write),
    .i_address_write(i_address_write),
    .i_taken(i_taken), .i_branch_address(i_branch_address),
    .i_ready(i_ready), .o_valid(o_valid), .o_instruction(o_instruction),
    .o_pc(o_pc), .o_pc_next(o_pc_next), .o_count(o_count), .o_fetch_pc(o_fetch_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory image, FIFO of {inst,pc}, one pending read slot.
  logic [31:0] m_mem [256];
  logic [63:0] m_q [$];
  logic        m_infl = 1'b0;
  logic [63:0] m_infl_e = '0;
  logic [31:0] m_pc = '0;

  // Advance model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    bit issue;
    if (rst) begin
      m_q.delete(); m_infl = 1'b0; m_pc = 32'h0;
    end else if (i_taken) begin
      m_q.delete(); m_infl = 1'b0; m_pc = i_branch_address;
    end else begin
      issue = i_step && !i_program_memory_write && (m_q.size() + int'(m_infl) < QD);
      if (m_q.size() > 0 && i_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_e);
      m_infl = issue;
      if (issue) begin
        m_infl_e = {m_mem[m_pc[9:2]], m_pc};
        m_pc = m_pc + 32'd4;
      end
    end
    if (i_program_memory_write) m_mem[i_address_write] = i_instruction_write;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [131:0] exp_vec();
    if (m_q.size() != 0)
      return {1'b1, 3'(m_q.size()), m_pc, m_q[0][63:32], m_q[0][31:0], m_q[0][31:0] + 32'd4};
    return {1'b0, 3'd0, m_pc, 96'd0};
  endfunction

  function automatic logic [131:0] obs_vec();
    return {o_valid, o_count, o_fetch_pc,
            (o_valid === 1'b1) ? {o_instruction, o_pc, o_pc_next} : 96'd0};
  endfunction

  task automatic load(input int addr, input logic [31:0] data);
    i_program_memory_write = 1'b1;
    i_address_write = 8'(addr);
    i_instruction_write = data;
    tick();
    i_program_memory_write = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    i_taken = 1'b1;
    i_branch_address = tgt;
    tick();
    i_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if ({o_valid, o_count} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b/%0d want 0/0", o_valid, o_count);
    end
    n_tests++;
    if ({o_instruction, o_pc, o_pc_next} !== 96'd0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h want 0 0 0", o_instruction, o_pc, o_pc_next);
    end
    n_tests++;
    if (o_fetch_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_fetch_pc got %h want 0", o_fetch_pc);
    end
    for (int i = 0; i < 256; i++) load(i, (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom);
  endtask

  task automatic test_stream();
    i_step = 1'b1; i_ready = 1'b1;
    redirect(32'h0);
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_early_valid got %b want 0", o_valid);
    end
    tick();
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if ({o_valid, o_instruction, o_pc, o_pc_next} !==
          {1'b1, 32'h1000_0000 + 32'(c), 32'(c * 4), 32'(c * 4 + 4)}) begin
        n_fail++;
        $display("FAIL stream_seq%0d got v=%b i=%h pc=%h nx=%h want i=%h pc=%h", c,
                 o_valid, o_instruction, o_pc, o_pc_next, 32'h1000_0000 + 32'(c), 32'(c * 4));
      end
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stream_model c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    i_step = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] got [$];
    i_step = 1'b1; i_ready = 1'b0;
    redirect(32'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bp_model c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if ({o_count, o_fetch_pc, o_instruction, o_pc} !== {3'd4, 32'h10, 32'h1000_0000, 32'h0}) begin
      n_fail++;
      $display("FAIL bp_full got cnt=%0d fpc=%h i=%h pc=%h want 4 10 10000000 0",
               o_count, o_fetch_pc, o_instruction, o_pc);
    end
    i_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 8; c++) begin
      if (o_valid === 1'b1) got.push_back({o_instruction, o_pc});
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bp_drain_model c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    n_tests++;
    if (got.size() != 8) begin
      n_fail++; $display("FAIL bp_drain_timeout got %0d entries want 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (got[k] !== {32'h1000_0000 + 32'(k), 32'(k * 4)}) begin
          n_fail++; $display("FAIL bp_order%0d got %h want %h", k, got[k],
                             {32'h1000_0000 + 32'(k), 32'(k * 4)});
        end
      end
    end
  endtask

  task automatic test_redirect();
    i_step = 1'b1; i_ready = 1'b0;
    redirect(32'h0);
    repeat (4) tick();
    n_tests++;
    if (o_count !== 3'd3) begin
      n_fail++; $display("FAIL redir_fill got %0d want 3", o_count);
    end
    i_ready = 1'b1;
    redirect(32'h14);
    n_tests++;
    if ({o_valid, o_count} !== 4'b0) begin
      n_fail++; $display("FAIL redir_flush got %b/%0d want 0/0", o_valid, o_count);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_gap got %b want 0", o_valid);
    end
    tick();
    n_tests++;
    if ({o_valid, o_pc, o_instruction} !== {1'b1, 32'h14, 32'h1000_0005}) begin
      n_fail++; $display("FAIL redir_target got v=%b pc=%h i=%h want 1 14 10000005",
                         o_valid, o_pc, o_instruction);
    end
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (obs_vec() !== exp_vec() || (o_valid === 1'b1 && o_pc === 32'hC)) begin
        n_fail++; $display("FAIL redir_model c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_step();
    logic [31:0] pc_before;
    logic [31:0] prev_pc;
    bit have_prev = 0;
    i_ready = 1'b1; i_step = 1'b1;
    redirect(32'h0);
    for (int c = 0; c < 16; c++) begin
      i_step = ((c % 4) == 0) || ((c % 4) == 3);
      pc_before = m_pc;
      tick();
      n_tests++;
      if (o_fetch_pc !== pc_before + (i_step ? 32'd4 : 32'd0)) begin
        n_fail++; $display("FAIL step_pc c%0d got %h want %h", c, o_fetch_pc,
                           pc_before + (i_step ? 32'd4 : 32'd0));
      end
      n_tests++;
      if (obs_vec() !== exp_vec() || (o_valid === 1'b1 && have_prev && o_pc !== prev_pc + 32'd4)) begin
        n_fail++; $display("FAIL step_order c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (o_valid === 1'b1) begin
        prev_pc = o_pc; have_prev = 1;
      end
    end
  endtask

  task automatic test_reset_midflight();
    i_step = 1'b1; i_ready = 1'b0;
    redirect(32'h0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({o_valid, o_count, o_fetch_pc, o_instruction} !== {1'b0, 3'd0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid got v=%b cnt=%0d fpc=%h i=%h want 0 0 0 0",
                         o_valid, o_count, o_fetch_pc, o_instruction);
    end
    i_ready = 1'b1;
    tick(); tick();
    n_tests++;
    if ({o_valid, o_pc, o_instruction} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      n_fail++; $display("FAIL rst_refetch got v=%b pc=%h i=%h want 1 0 10000000",
                         o_valid, o_pc, o_instruction);
    end
  endtask

  task automatic test_wrap();
    i_step = 1'b1; i_ready = 1'b1;
    redirect(32'h3FC);
    tick(); tick();
    n_tests++;
    if ({o_valid, o_pc, o_instruction} !== {1'b1, 32'h3FC, m_mem[255]}) begin
      n_fail++; $display("FAIL wrap_last got v=%b pc=%h i=%h want 1 3fc %h",
                         o_valid, o_pc, o_instruction, m_mem[255]);
    end
    tick();
    n_tests++;
    if ({o_valid, o_pc, o_pc_next, o_instruction} !== {1'b1, 32'h400, 32'h404, 32'h1000_0000}) begin
      n_fail++; $display("FAIL wrap_alias got v=%b pc=%h nx=%h i=%h want 1 400 404 10000000",
                         o_valid, o_pc, o_pc_next, o_instruction);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      i_taken = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 3))
        0:       i_branch_address = $urandom;
        1:       i_branch_address = 32'hFFFF_FFFC;
        default: i_branch_address = {22'd0, 8'($urandom), 2'b00};
      endcase
      i_step = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_program_memory_write = ($urandom_range(0, 19) == 0);
      i_address_write = 8'($urandom);
      i_instruction_write = $urandom;
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0; i_taken = 1'b0; i_program_memory_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_step();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
